dmem_arbiter: RTL and testbench

Two-requester arbiter and sequencer in front of the single-port `Data_Memory` (word array, asynchronous read, write on `clk` when `MemRW`=1). Port 0 is the core load/store unit; port 1 is the debug/DMA loader. The block serialises accesses, checks addresses, and converts byte-enabled partial writes into read-modify-write sequences. Each request gets exactly one response.

---
 rtl/dmem_arb_pkg.sv | 24 ++
 rtl/dmem_arb_pick.sv | 20 ++
 rtl/dmem_arbiter.sv | 173 +++++++++++++++++
 tb/tb_dmem_arbiter.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and helpers for the two-port data-memory arbiter.
package dmem_arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        RMW_WR = 1'b1
    } arb_state_e;

    localparam logic       PORT_CORE = 1'b0;
    localparam logic       PORT_DBG  = 1'b1;
    localparam logic [3:0] BE_FULL   = 4'hF;

    // Enabled lanes come from the new word, the rest keep the old word.
    function automatic logic [31:0] merge_be(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  be);
        logic [31:0] w_out;
        for (int i = 0; i < 4; i++) begin
            w_out[8*i +: 8] = be[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
        end
        return w_out;
    endfunction

endpackage

// File: rtl/dmem_arb_pick.sv
// Combinational grant selection; the preference input is held by the parent.
module dmem_arb_pick
    import dmem_arb_pkg::*;
(
    input  logic [1:0] i_req,
    input  logic       i_pref,
    output logic [1:0] o_gnt
);

    always_comb begin
        o_gnt = 2'b00;
        case (i_req)
            2'b01:   o_gnt = 2'b01;
            2'b10:   o_gnt = 2'b10;
            2'b11:   o_gnt = (i_pref == PORT_DBG) ? 2'b10 : 2'b01;
            default: o_gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer for the single-port data memory with partial-write RMW.
// Define DMEM_ARB_RR_EN for round-robin arbitration; otherwise port 0 has fixed priority.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [3:0]        p0_be,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_gnt,
    output logic              p0_rsp_valid,
    output logic              p0_rsp_err,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [3:0]        p1_be,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_gnt,
    output logic              p1_rsp_valid,
    output logic              p1_rsp_err,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              mem_MemRW,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_DataW,
    input  logic [DATA_W-1:0] mem_DataR
);

    arb_state_e        r_state;
    arb_state_e        w_state_nxt;
    logic [1:0]        w_req;
    logic [1:0]        w_gnt;
    logic              w_pref;
    logic              w_any;
    logic              w_sel;
    logic              w_we;
    logic [3:0]        w_be;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;
    logic [ADDR_W-1:0] w_widx;
    logic              w_err;
    logic              w_full;
    logic              w_none;
    logic              w_part;

    logic [1:0]        r_rsp_valid;
    logic [1:0]        r_rsp_err;
    logic [DATA_W-1:0] r_rdata [2];
    logic [ADDR_W-1:0] r_rmw_addr;
    logic [DATA_W-1:0] r_rmw_wdata;
    logic [3:0]        r_rmw_be;
    logic [DATA_W-1:0] r_rmw_old;
    logic              r_rmw_port;

`ifdef DMEM_ARB_RR_EN
    logic r_ptr;
    assign w_pref = r_ptr;
`else
    assign w_pref = PORT_CORE;
`endif

    // No grants while in reset or while the RMW write cycle owns the memory.
    assign w_req = (r_state == IDLE && !rst) ? {p1_req, p0_req} : 2'b00;

    dmem_arb_pick u_pick (
        .i_req  (w_req),
        .i_pref (w_pref),
        .o_gnt  (w_gnt)
    );

    assign w_any   = |w_gnt;
    assign w_sel   = w_gnt[1];
    assign w_we    = w_sel ? p1_we    : p0_we;
    assign w_be    = w_sel ? p1_be    : p0_be;
    assign w_addr  = w_sel ? p1_addr  : p0_addr;
    assign w_wdata = w_sel ? p1_wdata : p0_wdata;

    assign w_widx = {2'b00, w_addr[ADDR_W-1:2]};
    assign w_err  = (w_addr[1:0] != 2'b00) || (w_widx >= ADDR_W'(DEPTH));
    assign w_full = w_we && !w_err && (w_be == BE_FULL);
    assign w_none = w_we && (w_be == 4'h0);
    assign w_part = w_we && !w_err && !w_full && !w_none;

    assign p0_gnt       = w_gnt[0];
    assign p1_gnt       = w_gnt[1];
    assign p0_rsp_valid = r_rsp_valid[0];
    assign p1_rsp_valid = r_rsp_valid[1];
    assign p0_rsp_err   = r_rsp_err[0];
    assign p1_rsp_err   = r_rsp_err[1];
    assign p0_rdata     = r_rdata[0];
    assign p1_rdata     = r_rdata[1];

    always_comb begin
        w_state_nxt = r_state;
        mem_MemRW   = 1'b0;
        mem_addr    = '0;
        mem_DataW   = '0;
        case (r_state)
            IDLE: begin
                if (w_any && !w_err && !w_none) begin
                    mem_addr = w_widx;
                    if (w_full) begin
                        mem_MemRW = 1'b1;
                        mem_DataW = w_wdata;
                    end
                    if (w_part) begin
                        w_state_nxt = RMW_WR;
                    end
                end
            end
            RMW_WR: begin
                mem_addr    = r_rmw_addr;
                mem_MemRW   = !rst;
                mem_DataW   = merge_be(r_rmw_old, r_rmw_wdata, r_rmw_be);
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_rsp_valid <= 2'b00;
            r_rsp_err   <= 2'b00;
            r_rdata[0]  <= '0;
            r_rdata[1]  <= '0;
            r_rmw_addr  <= '0;
            r_rmw_wdata <= '0;
            r_rmw_be    <= 4'h0;
            r_rmw_old   <= '0;
            r_rmw_port  <= PORT_CORE;
`ifdef DMEM_ARB_RR_EN
            r_ptr       <= PORT_CORE;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_rsp_valid <= 2'b00;
            r_rsp_err   <= 2'b00;
            r_rdata[0]  <= '0;
            r_rdata[1]  <= '0;
            if (r_state == RMW_WR) begin
                r_rsp_valid[r_rmw_port] <= 1'b1;
            end else if (w_any) begin
                if (w_part) begin
                    r_rmw_addr  <= w_widx;
                    r_rmw_wdata <= w_wdata;
                    r_rmw_be    <= w_be;
                    r_rmw_old   <= mem_DataR;
                    r_rmw_port  <= w_sel;
                end else begin
                    r_rsp_valid[w_sel] <= 1'b1;
                    r_rsp_err[w_sel]   <= w_err;
                    r_rdata[w_sel]     <= (!w_we && !w_err) ? mem_DataR : '0;
                end
            end
`ifdef DMEM_ARB_RR_EN
            // The port just served loses the next tie.
            if (w_any) begin
                r_ptr <= ~w_sel;
            end
`endif
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed scoreboard bench for dmem_arbiter with a behavioural data memory.
module tb_dmem_arbiter;

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } rsp_t;

    logic        clk;
    logic        rst;
    logic        p0_req, p0_we, p1_req, p1_we;
    logic [3:0]  p0_be, p1_be;
    logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
    logic        p0_gnt, p0_rsp_valid, p0_rsp_err;
    logic        p1_gnt, p1_rsp_valid, p1_rsp_err;
    logic [31:0] p0_rdata, p1_rdata;
    logic        mem_MemRW;
    logic [31:0] mem_addr, mem_DataW, mem_DataR;

    logic [31:0] mem     [0:63];
    logic [31:0] ref_mem [0:63];
    rsp_t        q0[$];
    rsp_t        q1[$];
    int          vectors = 0;
    int          miscompares = 0;
    bit          mon_en = 1'b0;
    logic        memrw_g;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .DEPTH(64)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_be(p0_be), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_rsp_valid(p0_rsp_valid), .p0_rsp_err(p0_rsp_err), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_be(p1_be), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_rsp_valid(p1_rsp_valid), .p1_rsp_err(p1_rsp_err), .p1_rdata(p1_rdata),
        .mem_MemRW(mem_MemRW), .mem_addr(mem_addr), .mem_DataW(mem_DataW), .mem_DataR(mem_DataR)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_DataR = (mem_addr < 32'd64) ? mem[mem_addr[5:0]] : 32'h0;
    always @(posedge clk) begin
        if (mem_MemRW && mem_addr < 32'd64) mem[mem_addr[5:0]] <= mem_DataW;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
        logic [31:0] m;
        m = 32'h0;
        for (int i = 0; i < 4; i++) begin
            m = m | ((be[i] ? n : o) & (32'hFF << (8 * i)));
        end
        return m;
    endfunction

    // Drive one request, wait (bounded) for its grant, push the model's response.
    task automatic do_req(input int p, input logic we, input logic [3:0] be,
                          input logic [31:0] addr, input logic [31:0] wdata, output logic memrw);
        bit   got;
        bit   err;
        rsp_t r;
        @(negedge clk);
        if (p == 0) begin
            p0_req = 1'b1; p0_we = we; p0_be = be; p0_addr = addr; p0_wdata = wdata;
        end else begin
            p1_req = 1'b1; p1_we = we; p1_be = be; p1_addr = addr; p1_wdata = wdata;
        end
        #1;
        got = 1'b0;
        memrw = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if ((p == 0 && p0_gnt) || (p == 1 && p1_gnt)) begin
                got = 1'b1;
                memrw = mem_MemRW;
                break;
            end
            @(negedge clk);
            #1;
        end
        check($sformatf("gnt_p%0d_%h", p, addr), {31'b0, got}, 32'd1);
        err = (addr[1:0] != 2'b00) || ((addr >> 2) >= 32'd64);
        r.err = err;
        r.rdata = 32'h0;
        if (!err) begin
            if (!we) r.rdata = ref_mem[addr[7:2]];
            else if (be != 4'h0) ref_mem[addr[7:2]] = model_merge(ref_mem[addr[7:2]], wdata, be);
        end
        if (got) begin
            if (p == 0) q0.push_back(r);
            else q1.push_back(r);
        end
        @(negedge clk);
        if (p == 0) p0_req = 1'b0;
        else p1_req = 1'b0;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (p0_rsp_valid) begin
                if (q0.size() == 0) check("p0_rsp_unexpected", {31'b0, p0_rsp_valid}, 32'd0);
                else begin
                    rsp_t r;
                    r = q0.pop_front();
                    check("p0_rsp_err", {31'b0, p0_rsp_err}, {31'b0, r.err});
                    check("p0_rsp_rdata", p0_rdata, r.rdata);
                end
            end else check("p0_rdata_idle", p0_rdata, 32'h0);
            if (p1_rsp_valid) begin
                if (q1.size() == 0) check("p1_rsp_unexpected", {31'b0, p1_rsp_valid}, 32'd0);
                else begin
                    rsp_t r;
                    r = q1.pop_front();
                    check("p1_rsp_err", {31'b0, p1_rsp_err}, {31'b0, r.err});
                    check("p1_rsp_rdata", p1_rdata, r.rdata);
                end
            end else check("p1_rdata_idle", p1_rdata, 32'h0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        p0_req = 1'b1; p0_we = 1'b0; p0_be = 4'h0; p0_addr = 32'h44; p0_wdata = 32'h0;
        p1_req = 1'b1; p1_we = 1'b0; p1_be = 4'h0; p1_addr = 32'h3C; p1_wdata = 32'h0;

        // Reset: requests present but nothing granted, all outputs quiet.
        repeat (3) @(negedge clk);
        #1;
        check("rst_p0_gnt", {31'b0, p0_gnt}, 32'd0);
        check("rst_p1_gnt", {31'b0, p1_gnt}, 32'd0);
        check("rst_memrw", {31'b0, mem_MemRW}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_p0_vld", {31'b0, p0_rsp_valid}, 32'd0);
        check("rst_p1_vld", {31'b0, p1_rsp_valid}, 32'd0);
        check("rst_p0_rdata", p0_rdata, 32'h0);
        check("rst_p1_rdata", p1_rdata, 32'h0);
        @(negedge clk);
        p0_req = 1'b0; p1_req = 1'b0; rst = 1'b0;
        mon_en = 1'b1;

        // Preload through the debug port.
        do_req(1, 1'b1, 4'hF, 32'h44, 32'h0000_0038, memrw_g);
        check("preload_memrw", {31'b0, memrw_g}, 32'd1);
        do_req(1, 1'b1, 4'hF, 32'h10, 32'h1122_3344, memrw_g);
        do_req(1, 1'b1, 4'hF, 32'h08, 32'hCAFE_F00D, memrw_g);

        // Core read, response one cycle after grant.
        do_req(0, 1'b0, 4'h0, 32'h44, 32'h0, memrw_g);
        #1 check("rd_latency_p0_vld", {31'b0, p0_rsp_valid}, 32'd1);

        // Debug full write then read back.
        do_req(1, 1'b1, 4'hF, 32'h3C, 32'h0000_00C8, memrw_g);
        #1 check("wr_latency_p1_vld", {31'b0, p1_rsp_valid}, 32'd1);
        do_req(1, 1'b0, 4'h0, 32'h3C, 32'h0, memrw_g);

        // Partial write: memory read in grant cycle, merged write next, response after.
        do_req(0, 1'b1, 4'b0010, 32'h10, 32'hAABB_CCDD, memrw_g);
        check("rmw_grant_memrw", {31'b0, memrw_g}, 32'd0);
        #1;
        check("rmw_wr_memrw", {31'b0, mem_MemRW}, 32'd1);
        check("rmw_wr_addr", mem_addr, 32'h4);
        check("rmw_wr_data", mem_DataW, 32'h1122_CC44);
        check("rmw_wr_p0_vld", {31'b0, p0_rsp_valid}, 32'd0);
        @(negedge clk);
        #1;
        check("rmw_rsp_memrw", {31'b0, mem_MemRW}, 32'd0);
        check("rmw_rsp_p0_vld", {31'b0, p0_rsp_valid}, 32'd1);
        do_req(0, 1'b0, 4'h0, 32'h10, 32'h0, memrw_g);

        // Zero byte-enable write leaves memory alone.
        do_req(1, 1'b1, 4'h0, 32'h3C, 32'hDEAD_BEEF, memrw_g);
        check("be0_memrw", {31'b0, memrw_g}, 32'd0);
        do_req(1, 1'b0, 4'h0, 32'h3C, 32'h0, memrw_g);

        // Simultaneous reads; port 1 was served last.
        @(negedge clk);
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'h44;
        p1_req = 1'b1; p1_we = 1'b0; p1_addr = 32'h3C;
        for (int c = 0; c < 4; c++) begin
            logic [1:0] exp_g;
            rsp_t r;
`ifdef DMEM_ARB_RR_EN
            exp_g = (c % 2 == 1) ? 2'b10 : 2'b01;
`else
            exp_g = 2'b01;
`endif
            #1;
            check($sformatf("arb_gnt_%0d", c), {30'b0, p1_gnt, p0_gnt}, {30'b0, exp_g});
            r.err = 1'b0;
            if (p0_gnt) begin r.rdata = ref_mem[17]; q0.push_back(r); end
            if (p1_gnt) begin r.rdata = ref_mem[15]; q1.push_back(r); end
            @(negedge clk);
        end
        p0_req = 1'b0; p1_req = 1'b0;

        // Address errors: misaligned, out of range, misaligned write.
        do_req(0, 1'b0, 4'h0, 32'h42, 32'h0, memrw_g);
        check("mis_rd_memrw", {31'b0, memrw_g}, 32'd0);
        #1 check("mis_rd_rsp_memrw", {31'b0, mem_MemRW}, 32'd0);
        do_req(0, 1'b0, 4'h0, 32'h100, 32'h0, memrw_g);
        check("oor_rd_memrw", {31'b0, memrw_g}, 32'd0);
        do_req(0, 1'b1, 4'hF, 32'h101, 32'h1234_5678, memrw_g);
        check("mis_wr_memrw", {31'b0, memrw_g}, 32'd0);

        // Reset pulsed during RMW_WR aborts the write and the response.
        @(negedge clk);
        p0_req = 1'b1; p0_we = 1'b1; p0_be = 4'b0001; p0_addr = 32'h08; p0_wdata = 32'h0000_0055;
        #1 check("abort_gnt", {31'b0, p0_gnt}, 32'd1);
        @(negedge clk);
        p0_req = 1'b0;
        rst = 1'b1;
        #1;
        check("abort_memrw", {31'b0, mem_MemRW}, 32'd0);
        check("abort_mem_addr", mem_addr, 32'h0);
        check("abort_mem_dataw", mem_DataW, 32'h0);
        check("abort_p0_vld", {31'b0, p0_rsp_valid}, 32'd0);
        check("abort_p0_rdata", p0_rdata, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        do_req(0, 1'b0, 4'h0, 32'h08, 32'h0, memrw_g);

        repeat (3) @(negedge clk);
        check("q0_drained", 32'(q0.size()), 32'd0);
        check("q1_drained", 32'(q1.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
